// File: rtl/inst_fetch_unit_pkg.sv
// inst_fetch_unit_pkg: shared widths, reset defaults and the buffered fetch entry type.
package inst_fetch_unit_pkg;
    localparam int INST_W = 32;
    localparam int PC_W = 32;
    localparam logic [INST_W-1:0] INST_NOP = 32'h0;
    localparam logic [PC_W-1:0] DEF_RESET_PC = 32'h0000_0000;
    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: 2-entry in-order {pc,inst} FIFO with push, pop and flush; head is entry 0.
module fetch_skid_buf
    import inst_fetch_unit_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t head,
    output logic [1:0]   cnt
);
    fetch_entry_t mem [2];
    logic [1:0] wr_idx;
    assign wr_idx = cnt - 2'(pop);
    assign head = mem[0];
    // a push landing on slot 0 in the same cycle as a pop overrides the shift
    always_ff @(posedge clk) begin
        if (!rst_n || flush) cnt <= '0;
        else cnt <= cnt - 2'(pop) + 2'(push);
        if (pop) mem[0] <= mem[1];
        if (push) mem[wr_idx[0]] <= din;
    end
endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: PC, ROM issue, inflight tracking, bypass/skid output and optional perf counters.
// Counters are built only when FETCH_PERF_EN is defined; otherwise the perf ports read 0.
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter logic [PC_W-1:0] RESET_PC = DEF_RESET_PC
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [INST_W-1:0] rom_data_i,
    input  logic              redirect_i,
    input  logic [PC_W-1:0]   redirect_pc_i,
    output logic              if_valid_o,
    input  logic              id_ready_i,
    output logic [PC_W-1:0]   if_pc_o,
    output logic [INST_W-1:0] if_inst_o,
    output logic [31:0]       perf_fetch_o,
    output logic [31:0]       perf_stall_o
);
    logic [PC_W-1:0] pc, inflight_pc, redirect_base;
    logic inflight, has_buf, transfer, pop, push, issue;
    logic [1:0] cnt;
    fetch_entry_t head;
    assign redirect_base = redirect_pc_i & ~32'h3;
    assign has_buf = cnt != 2'd0;
    assign if_valid_o = (has_buf | inflight) & ~redirect_i;
    assign if_pc_o = has_buf ? head.pc : inflight ? inflight_pc : '0;
    assign if_inst_o = has_buf ? head.inst : inflight ? rom_data_i : INST_NOP;
    assign transfer = if_valid_o & id_ready_i;
    assign pop = transfer & has_buf;
    // returning word goes to the tail unless consumed directly through the bypass
    assign push = inflight & ~redirect_i & ~(transfer & ~has_buf);
    assign issue = redirect_i | (({1'b0, cnt} - 3'(pop) + 3'(inflight)) < 3'd2);
    assign rom_addr_o = !rst_n ? RESET_PC[ADDR_W+1:2] :
                        redirect_i ? redirect_base[ADDR_W+1:2] : pc[ADDR_W+1:2];
    fetch_skid_buf u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect_i),
        .din   ('{pc: inflight_pc, inst: rom_data_i}),
        .head  (head),
        .cnt   (cnt)
    );
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc <= RESET_PC;
            inflight <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect_i) begin
            pc <= redirect_base + 32'd4;
            inflight <= 1'b1;
            inflight_pc <= redirect_base;
        end else begin
            inflight <= issue;
            if (issue) begin
                pc <= pc + 32'd4;
                inflight_pc <= pc;
            end
        end
    end
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt, stall_cnt;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            fetch_cnt <= fetch_cnt + 32'(transfer);
            stall_cnt <= stall_cnt + 32'(if_valid_o & ~id_ready_i);
        end
    end
    assign perf_fetch_o = fetch_cnt;
    assign perf_stall_o = stall_cnt;
`else
    assign perf_fetch_o = '0;
    assign perf_stall_o = '0;
`endif
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: per-cycle vector table for fetch/stall/redirect/wrap plus a reset-mid-stall sequence.
module tb_inst_fetch_unit;
    logic clk = 1'b0;
    logic rst_n, redirect, ready;
    logic [7:0] rom_addr;
    logic [31:0] rom_data, redirect_pc, if_pc, if_inst, perf_fetch, perf_stall;
    logic if_valid;
    int checks = 0, errors = 0;
    int exp_fetch = 0, exp_stall = 0;

    inst_fetch_unit #(.ADDR_W(8), .RESET_PC(32'h0)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rom_addr_o    (rom_addr),
        .rom_data_i    (rom_data),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .if_valid_o    (if_valid),
        .id_ready_i    (ready),
        .if_pc_o       (if_pc),
        .if_inst_o     (if_inst),
        .perf_fetch_o  (perf_fetch),
        .perf_stall_o  (perf_stall)
    );

    always #5 clk = ~clk;
    always @(posedge clk) rom_data <= {20'b0, rom_addr, 4'b0};

    typedef struct {
        logic rst_n, rdy, redir;
        logic [31:0] rpc;
        logic v;
        logic [31:0] pc;
        logic [7:0] addr;
    } vec_t;
    vec_t vecs [25];

    function automatic vec_t mk(logic r, logic y, logic d, logic [31:0] rp, logic v, logic [31:0] p, logic [7:0] a);
        mk = '{rst_n: r, rdy: y, redir: d, rpc: rp, v: v, pc: p, addr: a};
    endfunction

    function automatic logic [31:0] rom_word(logic [31:0] p);
        rom_word = {20'b0, p[9:2], 4'b0};
    endfunction

    task automatic chk(string name, int row, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, got, exp);
        end
    endtask

    initial begin
        vecs[0]  = mk(0, 1, 0, 0, 0, 32'h0, 8'h00);
        vecs[1]  = mk(1, 1, 0, 0, 0, 32'h0, 8'h00);
        vecs[2]  = mk(1, 1, 0, 0, 1, 32'h0, 8'h01);
        vecs[3]  = mk(1, 1, 0, 0, 1, 32'h4, 8'h02);
        vecs[4]  = mk(1, 0, 0, 0, 1, 32'h8, 8'h03);
        vecs[5]  = mk(1, 0, 0, 0, 1, 32'h8, 8'h04);
        vecs[6]  = mk(1, 0, 0, 0, 1, 32'h8, 8'h04);
        vecs[7]  = mk(1, 0, 0, 0, 1, 32'h8, 8'h04);
        vecs[8]  = mk(1, 1, 0, 0, 1, 32'h8, 8'h04);
        vecs[9]  = mk(1, 1, 0, 0, 1, 32'hC, 8'h05);
        vecs[10] = mk(1, 1, 0, 0, 1, 32'h10, 8'h06);
        vecs[11] = mk(1, 1, 0, 0, 1, 32'h14, 8'h07);
        vecs[12] = mk(1, 0, 0, 0, 1, 32'h18, 8'h08);
        vecs[13] = mk(1, 0, 1, 32'h323, 0, 32'h0, 8'hC8);
        vecs[14] = mk(1, 0, 0, 0, 1, 32'h320, 8'hC9);
        vecs[15] = mk(1, 1, 0, 0, 1, 32'h320, 8'hCA);
        vecs[16] = mk(1, 1, 0, 0, 1, 32'h324, 8'hCB);
        vecs[17] = mk(1, 1, 1, 32'h100, 0, 32'h0, 8'h40);
        vecs[18] = mk(1, 1, 1, 32'h200, 0, 32'h0, 8'h80);
        vecs[19] = mk(1, 1, 0, 0, 1, 32'h200, 8'h81);
        vecs[20] = mk(1, 1, 0, 0, 1, 32'h204, 8'h82);
        vecs[21] = mk(1, 1, 1, 32'h3FC, 0, 32'h0, 8'hFF);
        vecs[22] = mk(1, 1, 0, 0, 1, 32'h3FC, 8'h00);
        vecs[23] = mk(1, 1, 0, 0, 1, 32'h400, 8'h01);
        vecs[24] = mk(1, 0, 0, 0, 1, 32'h404, 8'h02);

        rst_n = 1'b0; ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            rst_n = vecs[i].rst_n; ready = vecs[i].rdy;
            redirect = vecs[i].redir; redirect_pc = vecs[i].rpc;
            #1;
            chk("valid", i, 32'(if_valid), 32'(vecs[i].v));
            chk("rom_addr", i, 32'(rom_addr), 32'(vecs[i].addr));
            if (vecs[i].v) begin
                chk("pc", i, if_pc, vecs[i].pc);
                chk("inst", i, if_inst, rom_word(vecs[i].pc));
            end
            if (!vecs[i].rst_n) begin
                chk("rst_pc", i, if_pc, 32'h0);
                chk("rst_inst", i, if_inst, 32'h0);
                chk("rst_perf_fetch", i, perf_fetch, 32'h0);
            end
            if (vecs[i].rst_n && vecs[i].v) begin
                if (vecs[i].rdy) exp_fetch++;
                else exp_stall++;
            end
        end
        @(negedge clk);
`ifdef FETCH_PERF_EN
        chk("perf_fetch", 99, perf_fetch, 32'(exp_fetch));
        chk("perf_stall", 99, perf_stall, 32'(exp_stall));
`else
        chk("perf_fetch_off", 99, perf_fetch, 32'h0);
        chk("perf_stall_off", 99, perf_stall, 32'h0);
`endif
        ready = 1'b0; redirect = 1'b0;
        repeat (3) @(negedge clk);
        #1 chk("stall_hold_valid", 100, 32'(if_valid), 32'h1);
        chk("stall_hold_pc", 100, if_pc, 32'h404);
        rst_n = 1'b0; redirect = 1'b1; redirect_pc = 32'h500;
        #1 chk("rst_addr_override", 101, 32'(rom_addr), 32'h0);
        @(negedge clk);
        redirect = 1'b0;
        #1 chk("rst_mid_valid", 102, 32'(if_valid), 32'h0);
        chk("rst_mid_pc", 102, if_pc, 32'h0);
        chk("rst_mid_perf", 102, perf_stall, 32'h0);
        @(negedge clk);
        rst_n = 1'b1; ready = 1'b1;
        #1 chk("post_rst_valid", 103, 32'(if_valid), 32'h0);
        chk("post_rst_addr", 103, 32'(rom_addr), 32'h0);
        @(negedge clk);
        #1 chk("post_rst_first_valid", 104, 32'(if_valid), 32'h1);
        chk("post_rst_first_pc", 104, if_pc, 32'h0);
        chk("post_rst_first_inst", 104, if_inst, 32'h0);
        @(negedge clk);
        #1 chk("post_rst_second_pc", 105, if_pc, 32'h4);
        chk("post_rst_second_inst", 105, if_inst, 32'h10);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
